// File: rtl/calc_pkg.sv
// Shared types and ASCII constants for the calculator command sequencer.
package calc_pkg;

   typedef enum logic [2:0] {
      StGetA,
      StGetOp,
      StGetB,
      StIssue,
      StWait,
      StErr,
      StEmit
   } state_e;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ERR   = 8'h3F;
   localparam logic [7:0] ASCII_TMO   = 8'h21;

   function automatic logic ascii_is_digit(logic [7:0] c);
      return (c >= ASCII_0) && (c <= ASCII_9);
   endfunction

endpackage

// File: rtl/calc_char_class.sv
// Combinational classifier for incoming command bytes.
module calc_char_class
   import calc_pkg::*;
(
   input  logic [7:0] rx_data,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_sub,
   output logic       is_space
);

   assign is_digit = ascii_is_digit(rx_data);
   assign is_sub   = (rx_data == ASCII_MINUS);
   assign is_op    = (rx_data == ASCII_PLUS) || is_sub;
   assign is_space = (rx_data == ASCII_SPACE);

endmodule

// File: rtl/calc_cmd_sequencer.sv
// Parses "<digit> <op> <digit>" from the RX byte stream, runs one adder operation and
// returns the result byte on TX. Optional WAIT timeout enabled by CALC_SEQ_TIMEOUT_EN.
module calc_cmd_sequencer
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter bit          SPACE_SKIP     = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       adder_start,
   output logic       adder_subtract,
   output logic [7:0] adder_r1,
   output logic [7:0] adder_r2,
   input  logic [7:0] adder_data,
   input  logic       adder_rdy,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       busy
);

   state_e state_q;
   logic   is_digit, is_op, is_sub, is_space;
   logic   accept, skip, timeout;

   calc_char_class u_char_class (
      .rx_data  (rx_data),
      .is_digit (is_digit),
      .is_op    (is_op),
      .is_sub   (is_sub),
      .is_space (is_space)
   );

   assign rx_ready = (state_q == StGetA) || (state_q == StGetOp) || (state_q == StGetB);
   assign busy     = (state_q != StGetA);
   assign accept   = rx_valid && rx_ready;
   assign skip     = SPACE_SKIP && is_space;

`ifdef CALC_SEQ_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CntW-1:0] wait_cnt_q;

   // Asserted during the last permitted WAIT cycle.
   assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StGetA;
         adder_start    <= 1'b0;
         adder_subtract <= 1'b0;
         adder_r1       <= 8'h00;
         adder_r2       <= 8'h00;
         tx_valid       <= 1'b0;
         tx_data        <= 8'h00;
`ifdef CALC_SEQ_TIMEOUT_EN
         wait_cnt_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            StGetA: begin
               if (accept && !skip) begin
                  if (is_digit) begin
                     adder_r1 <= rx_data;
                     state_q  <= StGetOp;
                  end else begin
                     state_q  <= StErr;
                  end
               end
            end
            StGetOp: begin
               if (accept && !skip) begin
                  if (is_op) begin
                     adder_subtract <= is_sub;
                     state_q        <= StGetB;
                  end else begin
                     state_q        <= StErr;
                  end
               end
            end
            StGetB: begin
               if (accept && !skip) begin
                  if (is_digit) begin
                     adder_r2    <= rx_data;
                     adder_start <= 1'b1;
                     state_q     <= StIssue;
                  end else begin
                     state_q     <= StErr;
                  end
               end
            end
            StIssue: begin
               adder_start <= 1'b0;
               state_q     <= StWait;
`ifdef CALC_SEQ_TIMEOUT_EN
               wait_cnt_q  <= '0;
`endif
            end
            StWait: begin
               // A ready pulse coinciding with expiry still delivers the result.
               if (adder_rdy) begin
                  tx_data  <= adder_data;
                  tx_valid <= 1'b1;
                  state_q  <= StEmit;
               end else if (timeout) begin
                  tx_data  <= ASCII_TMO;
                  tx_valid <= 1'b1;
                  state_q  <= StEmit;
               end else begin
`ifdef CALC_SEQ_TIMEOUT_EN
                  wait_cnt_q <= wait_cnt_q + CntW'(1);
`endif
               end
            end
            StErr: begin
               tx_data  <= ASCII_ERR;
               tx_valid <= 1'b1;
               state_q  <= StEmit;
            end
            StEmit: begin
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state_q  <= StGetA;
               end
            end
            default: state_q <= StGetA;
         endcase
      end
   end

endmodule

// File: doc/calc_cmd_sequencer.md
Name: calc_cmd_sequencer

Overview:
- Sequences the shared 4-bit ASCII adder/subtractor datapath from a byte-serial command stream.
- Parses `<digit> <op> <digit>` in ASCII, drives one adder operation, waits for the adder's ready pulse, then returns the adder's ASCII result byte on a transmit handshake.
- Sits between the UART RX/TX byte interfaces and the adder datapath. It is the only master of the adder's start, subtract and operand inputs.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT before abort (used only with the optional feature).
- SPACE_SKIP, 1, when 1, 0x20 bytes are consumed and ignored in every GET state; when 0, they are invalid characters.

Ports:
- clk  in  1  global clock
- rst  in  1  reset, synchronous, active-high
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  received ASCII byte
- rx_ready  out  1  sequencer accepts rx_data this cycle
- adder_start  out  1  one-cycle start pulse to adder
- adder_subtract  out  1  1 = subtract, 0 = add
- adder_r1  out  8  operand A (raw ASCII digit)
- adder_r2  out  8  operand B (raw ASCII digit)
- adder_data  in  8  adder ASCII result
- adder_rdy  in  1  adder result-valid pulse
- tx_valid  out  1  tx_data holds an output byte
- tx_data  out  8  output ASCII byte
- tx_ready  in  1  consumer accepts tx_data
- busy  out  1  high in any state other than GET_A

Behaviour:
- Reset values: state GET_A; rx_ready 1; adder_start 0; adder_subtract 0; adder_r1/adder_r2 0x00; tx_valid 0; tx_data 0x00; busy 0. Reset in any state, including WAIT or EMIT, aborts the operation and drops any pending tx byte.
- Byte acceptance: a byte is consumed when rx_valid && rx_ready.
  - rx_ready = 1 only in GET_A, GET_OP and GET_B.
- Character classes:
  - Digit: 0x30..0x39.
  - Operator: '+' (0x2B) or '-' (0x2D).
  - Space: 0x20.
- GET_A:
  - Digit: capture into adder_r1, go to GET_OP.
  - Space: ignored when SPACE_SKIP=1.
  - Anything else: go to ERR.
- GET_OP:
  - '+': subtract := 0, go to GET_B.
  - '-': subtract := 1, go to GET_B.
  - Space: ignored when SPACE_SKIP=1.
  - Anything else: go to ERR.
- GET_B:
  - Digit: capture into adder_r2, go to ISSUE.
  - Space: ignored when SPACE_SKIP=1.
  - Anything else: go to ERR.
- ISSUE: adder_start = 1 for exactly one cycle, then go to WAIT.
- WAIT: adder_r1, adder_r2 and adder_subtract are held stable. When adder_rdy = 1, register adder_data into tx_data and go to EMIT.
  - Adder ready arrives 5 cycles after start. Any latency of 1 or more cycles is accepted.
- adder_rdy outside WAIT is ignored.
- ERR: load tx_data = 0x3F ('?'), go to EMIT. The offending byte has already been consumed.
- EMIT: tx_valid = 1 and tx_data held stable until tx_ready.
  - On the handshake cycle, go to GET_A. tx_valid is 0 on the following cycle.
  - tx_ready low holds the state indefinitely. No rx bytes are accepted while in EMIT.
- Throughput: one result byte per command. Minimum 3 accepted bytes + 1 ISSUE + adder latency + 1 EMIT per command.
- adder_start is a registered output with no combinational path from rx_* or tx_*.

Optional Feature:
- Macro CALC_SEQ_TIMEOUT_EN.
- Defined: a WAIT-state counter starts at 0 on entry to WAIT. If it reaches TIMEOUT_CYCLES without adder_rdy, load tx_data = 0x21 ('!') and go to EMIT.
  - adder_rdy on the same cycle as expiry wins: the result is emitted.
- Not defined: no counter is built, and WAIT lasts until adder_rdy.

Decomposition:
- Shared package calc_pkg:
  - state encoding for GET_A, GET_OP, GET_B, ISSUE, WAIT, ERR, EMIT;
  - ASCII constants: ASCII_0, ASCII_9, ASCII_PLUS, ASCII_MINUS, ASCII_SPACE, ASCII_ERR (0x3F), ASCII_TMO (0x21).
- One natural sub-module, calc_char_class: combinational classifier producing is_digit, is_op, is_sub and is_space from rx_data.

Test Plan:
- Add: send 0x33, 0x2B, 0x34 with tx_ready = 1. Expect:
  - exactly one adder_start;
  - adder_r1 = 0x33, adder_r2 = 0x34, subtract = 0;
  - after adder_rdy, tx_data = 0x37 with tx_valid for 1 cycle.
- Subtract with underflow: send '3', '-', '5' against the team adder model. Expect subtract = 1 and tx_data = adder_data = 0x5E; busy is 0 after the handshake.
- Spaces and errors:
  - 0x33, 0x20, 0x2B, 0x20, 0x31 yields result 0x34.
  - 0x33, 0x78 yields tx_data 0x3F, no adder_start, and a return to GET_A.
- Backpressure: hold tx_ready = 0 for 20 cycles after the result. Expect tx_valid and tx_data stable, rx_ready = 0 throughout; the handshake on tx_ready = 1 returns to GET_A.
- Reset mid-operation: assert rst for 1 cycle during WAIT. Expect all outputs at reset values on the next cycle, and a late adder_rdy ignored with no tx_valid.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): suppress adder_rdy. Expect tx_data = 0x21 after 16 WAIT cycles. With the macro undefined, the sequencer stays in WAIT with busy = 1.
